// File: rtl/pipe_exe_muldiv_pkg.sv
// Shared op codes and helpers for the EXE-stage multiply/divide unit.
// The ID-stage decoder imports the same op encoding.
package pipe_exe_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } md_kind_e;

    // Any op that reads or writes HI/LO, and so must wait for a running op.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/pipe_exe_muldiv_if.sv
// EXE-stage side of the multiply/divide unit: op and operands in, HI/LO, stall and result out.
interface pipe_exe_muldiv_if #(parameter int WIDTH = 32);

    logic [3:0]       eop;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             md_stall;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output eop, ea, eb,
        input  md_stall, md_result, hi, lo, busy
    );

    modport slave (
        input  eop, ea, eb,
        output md_stall, md_result, hi, lo, busy
    );

endinterface

// File: rtl/pipe_exe_muldiv_seq_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle, with sign fixup applied to the final step's result.
module muldiv_seq_core
    import pipe_exe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   a_raw;
    md_kind_e           kind;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
    assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign div_sh  = {acc, q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, m};

    // For MUL, {acc,q} is the partial product shifting right; for DIV, acc is the
    // partial remainder and q shifts the dividend out while quotient bits shift in.
    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        if (kind == KIND_MUL) begin
            acc_nxt = mul_sum[WIDTH:1];
            q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
        end else if (div_ge) begin
            acc_nxt = WIDTH'(div_sh - {1'b0, m});
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = div_sh[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end
    end

    assign prod_raw = {acc_nxt, q_nxt};
    assign prod_fix = neg_lo ? -prod_raw : prod_raw;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (kind == KIND_MUL) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = neg_hi ? -acc_nxt : acc_nxt;
            res_lo = neg_lo ? -q_nxt : q_nxt;
        end
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            a_raw    <= '0;
            kind     <= KIND_MUL;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else if (busy) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            acc      <= '0;
            q        <= is_div ? a_mag : b_mag;
            m        <= is_div ? b_mag : a_mag;
            a_raw    <= a;
            kind     <= is_div ? KIND_DIV : KIND_MUL;
            neg_lo   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi   <= is_signed && a[WIDTH-1];
            div_zero <= is_div && (b == '0);
            busy     <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_exe_muldiv.sv
// EXE-stage multiply/divide unit: HI/LO registers, op decode, hazard stall and MFHI/MFLO result.
module pipe_exe_muldiv
    import pipe_exe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input logic               clk,
    input logic               clr,
    pipe_exe_muldiv_if.slave  bus
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             core_busy;
    logic             core_done;
    logic             core_start;
    logic             core_div;
    logic             core_signed;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

    assign core_start  = !core_busy && (bus.eop inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    assign core_div    = (bus.eop == MD_DIV) || (bus.eop == MD_DIVU);
    assign core_signed = (bus.eop == MD_MULT) || (bus.eop == MD_DIV);

    muldiv_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .clr       (clr),
        .start     (core_start),
        .is_div    (core_div),
        .is_signed (core_signed),
        .a         (bus.ea),
        .b         (bus.eb),
        .busy      (core_busy),
        .done      (core_done),
        .res_hi    (core_hi),
        .res_lo    (core_lo)
    );

    // MTHI/MTLO only take effect when idle; a stalled move waits for the final write.
    always_ff @(posedge clk) begin
        if (clr) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (core_done) begin
            hi_r <= core_hi;
            lo_r <= core_lo;
        end else if (!core_busy) begin
            if (bus.eop == MD_MTHI) hi_r <= bus.ea;
            if (bus.eop == MD_MTLO) lo_r <= bus.ea;
        end
    end

    always_comb begin
        bus.md_result = '0;
        if (bus.eop == MD_MFHI) bus.md_result = hi_r;
        else if (bus.eop == MD_MFLO) bus.md_result = lo_r;
    end

    assign bus.md_stall = core_busy && is_md_op(bus.eop);
    assign bus.busy     = core_busy;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Self-checking bench: directed corner cases then randomized ops against a cycle-level
// reference model computing HI/LO with plain 64-bit arithmetic.
module tb_pipe_exe_muldiv;
    import pipe_exe_muldiv_pkg::*;

    logic clk;
    logic clr;

    pipe_exe_muldiv_if bus();

    pipe_exe_muldiv dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    int          m_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic touches_hilo(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    // Architectural result of a MULT/DIV op, computed directly from the op's meaning.
    task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd1: begin
                sp = sa * sb;
                {m_pend_hi, m_pend_lo} = sp;
            end
            4'd2: begin
                up = ua * ub;
                {m_pend_hi, m_pend_lo} = up;
            end
            4'd3: begin
                if (b == 32'd0) begin
                    m_pend_lo = 32'hFFFFFFFF;
                    m_pend_hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    m_pend_lo = 32'h80000000;
                    m_pend_hi = 32'd0;
                end else begin
                    m_pend_lo = 32'(sa / sb);
                    m_pend_hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    m_pend_lo = 32'hFFFFFFFF;
                    m_pend_hi = a;
                end else begin
                    m_pend_lo = 32'(ua / ub);
                    m_pend_hi = 32'(ua % ub);
                end
            end
        endcase
    endtask

    task automatic model_edge(input logic c, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (c) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else begin
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4: begin
                    model_compute(op, a, b);
                    m_left = 32;
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One pipeline cycle: drive at the falling edge, check, then advance DUT and model together.
    task automatic applyStimulus(input logic c, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        exp_stall;
        logic [31:0] exp_res;
        clr     = c;
        bus.eop = op;
        bus.ea  = a;
        bus.eb  = b;
        #1;
        exp_stall = (m_left > 0) && touches_hilo(op);
        exp_res   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        checkOutput("md_stall", {31'b0, bus.md_stall}, {31'b0, exp_stall});
        checkOutput("busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
        checkOutput("hi", bus.hi, m_hi);
        checkOutput("lo", bus.lo, m_lo);
        if (!exp_stall) checkOutput("md_result", bus.md_result, exp_res);
        @(posedge clk);
        model_edge(c, op, a, b);
        @(negedge clk);
    endtask

    // Hold an op in EX while the model says it must stall, then let it execute.
    task automatic issueHeld(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int stalls);
        stalls = 0;
        while ((m_left > 0) && touches_hilo(op) && (stalls < 100)) begin
            applyStimulus(1'b0, op, a, b);
            stalls++;
        end
        applyStimulus(1'b0, op, a, b);
    endtask

    task automatic drainIdle();
        int n;
        n = 0;
        while ((m_left > 0) && (n < 100)) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
            n++;
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int          stalls;
        int          n;
        logic [3:0]  op_r;
        logic [31:0] a_r, b_r;

        m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0; m_left = 0;
        clr = 1'b1; bus.eop = 4'd0; bus.ea = '0; bus.eb = '0;
        @(negedge clk);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        checkOutput("reset_hi", bus.hi, 32'd0);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);

        issueHeld(MD_MULT, 32'hFFFFFFFD, 32'd7, stalls);
        n = 0;
        while (m_left > 0 && n < 100) begin applyStimulus(1'b0, 4'd0, 32'd0, 32'd0); n++; end
        checkOutput("mult_busy_cycles", 32'(n), 32'd32);
        checkOutput("mult_hi", bus.hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", bus.lo, 32'hFFFFFFEB);

        issueHeld(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, stalls);
        drainIdle();
        checkOutput("multu_hi", bus.hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", bus.lo, 32'h00000001);

        issueHeld(MD_DIV, 32'hFFFFFFF9, 32'd2, stalls);
        drainIdle();
        checkOutput("div_lo", bus.lo, 32'hFFFFFFFD);
        checkOutput("div_hi", bus.hi, 32'hFFFFFFFF);

        issueHeld(MD_DIVU, 32'd7, 32'd0, stalls);
        drainIdle();
        checkOutput("divu0_lo", bus.lo, 32'hFFFFFFFF);
        checkOutput("divu0_hi", bus.hi, 32'd7);

        issueHeld(MD_DIV, 32'h80000000, 32'hFFFFFFFF, stalls);
        drainIdle();
        checkOutput("divovf_lo", bus.lo, 32'h80000000);
        checkOutput("divovf_hi", bus.hi, 32'd0);

        applyStimulus(1'b0, MD_MULT, 32'd6, 32'd7);
        n = 0;
        while (m_left > 0 && n < 100) begin applyStimulus(1'b0, MD_MFLO, 32'd0, 32'd0); n++; end
        checkOutput("mflo_stalls", 32'(n), 32'd32);
        bus.eop = MD_MFLO;
        #1;
        checkOutput("mflo_result", bus.md_result, 32'd42);
        checkOutput("mflo_nostall", {31'b0, bus.md_stall}, 32'd0);
        applyStimulus(1'b0, MD_MFLO, 32'd0, 32'd0);

        applyStimulus(1'b0, MD_MULT, 32'd1234, 32'd5678);
        issueHeld(MD_DIV, 32'd100, 32'd7, stalls);
        checkOutput("div_after_mult_stalls", 32'(stalls), 32'd32);
        drainIdle();
        checkOutput("b2b_lo", bus.lo, 32'd14);
        checkOutput("b2b_hi", bus.hi, 32'd2);

        applyStimulus(1'b0, MD_MTHI, 32'h55, 32'd0);
        applyStimulus(1'b0, MD_MTLO, 32'hAA, 32'd0);
        issueHeld(MD_DIV, 32'd1000, 32'd3, stalls);
        repeat (22) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        checkOutput("clr_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("clr_hi", bus.hi, 32'd0);
        checkOutput("clr_lo", bus.lo, 32'd0);
        bus.eop = MD_MFHI;
        #1;
        checkOutput("clr_stall", {31'b0, bus.md_stall}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);

        applyStimulus(1'b0, MD_MTHI, 32'h1234, 32'd0);
        checkOutput("mthi", bus.hi, 32'h1234);

        op_r = 4'd0; a_r = '0; b_r = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!((m_left > 0) && touches_hilo(op_r))) begin
                op_r = 4'($urandom_range(0, 15));
                a_r  = pick_val();
                b_r  = pick_val();
            end
            applyStimulus(($urandom_range(0, 299) == 0), op_r, a_r, b_r);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
